// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered common-data-bus port between the ALU
// result path (ex_*) and the load-unit result path (ld_*). Each source is
// buffered in a DEPTH-entry FIFO; the bus is granted round-robin and the
// granted head is registered onto cdb_*. A flush discards every buffered
// result.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (low = freeze all state)
//   flush             mispredict flush, empties both FIFOs
//   ex_valid/ex_rob_id/ex_val/ex_rel_pc, ex_ready   ALU result in
//   ld_valid/ld_rob_id/ld_val, ld_ready             load result in
//   cdb_flag/cdb_src/cdb_rob_id/cdb_val/cdb_rel_pc  registered broadcast
//
// Build option: define CDB_FIXED_PRIO_EN to give the load FIFO fixed
// priority when both FIFOs are non-empty (no round-robin state).
module cdb_arbiter #(
  parameter int ROB_ID_W = 4,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [ROB_ID_W-1:0] ex_rob_id,
  input  logic [31:0]         ex_val,
  input  logic [31:0]         ex_rel_pc,
  output logic                ex_ready,
  input  logic                ld_valid,
  input  logic [ROB_ID_W-1:0] ld_rob_id,
  input  logic [31:0]         ld_val,
  output logic                ld_ready,
  output logic                cdb_flag,
  output logic                cdb_src,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [31:0]         cdb_val,
  output logic [31:0]         cdb_rel_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ROB_ID_W-1:0] ex_id_mem [DEPTH];
  logic [31:0]         ex_val_mem[DEPTH];
  logic [31:0]         ex_pc_mem [DEPTH];
  logic [ROB_ID_W-1:0] ld_id_mem [DEPTH];
  logic [31:0]         ld_val_mem[DEPTH];

  logic [PW-1:0] ex_head, ex_tail, ld_head, ld_tail;
  logic [CW-1:0] ex_count, ld_count;

`ifndef CDB_FIXED_PRIO_EN
  logic last_grant;  // 0 = ALU, 1 = load
`endif

  logic en;
  logic ex_push, ld_push, grant_ex, grant_ld;

  // Grant looks only at pre-push occupancy, so a push can never be
  // broadcast in the same cycle (no input-to-output path).
  always_comb begin
    en       = rdy && !flush;
    ex_ready = !rst && en && (ex_count < CW'(DEPTH));
    ld_ready = !rst && en && (ld_count < CW'(DEPTH));
    ex_push  = ex_valid && ex_ready;
    ld_push  = ld_valid && ld_ready;
`ifdef CDB_FIXED_PRIO_EN
    grant_ld = en && (ld_count != '0);
`else
    grant_ld = en && (ld_count != '0) && ((ex_count == '0) || !last_grant);
`endif
    grant_ex = en && (ex_count != '0) && !grant_ld;
  end

  always_ff @(posedge clk) begin
    if (ex_push) begin
      ex_id_mem[ex_tail]  <= ex_rob_id;
      ex_val_mem[ex_tail] <= ex_val;
      ex_pc_mem[ex_tail]  <= ex_rel_pc;
    end
    if (ld_push) begin
      ld_id_mem[ld_tail]  <= ld_rob_id;
      ld_val_mem[ld_tail] <= ld_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_head    <= '0;
      ex_tail    <= '0;
      ex_count   <= '0;
      ld_head    <= '0;
      ld_tail    <= '0;
      ld_count   <= '0;
      cdb_flag   <= 1'b0;
      cdb_src    <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_rel_pc <= '0;
`ifndef CDB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else if (rdy) begin
      if (flush) begin
        ex_head  <= '0;
        ex_tail  <= '0;
        ex_count <= '0;
        ld_head  <= '0;
        ld_tail  <= '0;
        ld_count <= '0;
        cdb_flag <= 1'b0;
      end else begin
        if (ex_push) ex_tail <= ex_tail + 1'b1;
        if (ld_push) ld_tail <= ld_tail + 1'b1;
        if (grant_ex) ex_head <= ex_head + 1'b1;
        if (grant_ld) ld_head <= ld_head + 1'b1;
        ex_count <= ex_count + CW'(ex_push) - CW'(grant_ex);
        ld_count <= ld_count + CW'(ld_push) - CW'(grant_ld);

        cdb_flag <= grant_ex || grant_ld;
        if (grant_ex) begin
          cdb_src    <= 1'b0;
          cdb_rob_id <= ex_id_mem[ex_head];
          cdb_val    <= ex_val_mem[ex_head];
          cdb_rel_pc <= ex_pc_mem[ex_head];
        end else if (grant_ld) begin
          cdb_src    <= 1'b1;
          cdb_rob_id <= ld_id_mem[ld_head];
          cdb_val    <= ld_val_mem[ld_head];
          cdb_rel_pc <= '0;
        end
`ifndef CDB_FIXED_PRIO_EN
        if (grant_ex)      last_grant <= 1'b0;
        else if (grant_ld) last_grant <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based
// model of the arbiter's broadcast rules.
module tb_cdb_arbiter;

  localparam int W = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, rdy, flush;
  logic         ex_valid, ld_valid;
  logic [W-1:0] ex_rob_id, ld_rob_id;
  logic [31:0]  ex_val, ex_rel_pc, ld_val;
  logic         ex_ready, ld_ready;
  logic         cdb_flag, cdb_src;
  logic [W-1:0] cdb_rob_id;
  logic [31:0]  cdb_val, cdb_rel_pc;

  cdb_arbiter #(.ROB_ID_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ex_valid(ex_valid), .ex_rob_id(ex_rob_id), .ex_val(ex_val),
    .ex_rel_pc(ex_rel_pc), .ex_ready(ex_ready),
    .ld_valid(ld_valid), .ld_rob_id(ld_rob_id), .ld_val(ld_val),
    .ld_ready(ld_ready),
    .cdb_flag(cdb_flag), .cdb_src(cdb_src), .cdb_rob_id(cdb_rob_id),
    .cdb_val(cdb_val), .cdb_rel_pc(cdb_rel_pc)
  );

  typedef struct {
    logic [W-1:0] id;
    logic [31:0]  val;
    logic [31:0]  pc;
  } ent_t;

  ent_t exq[$];
  ent_t ldq[$];
  logic m_last;
  logic m_flag, m_src;
  logic [W-1:0] m_id;
  logic [31:0] m_val, m_pc;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_ex_ready();
    return !rst && rdy && !flush && (exq.size() < D);
  endfunction

  function automatic logic m_ld_ready();
    return !rst && rdy && !flush && (ldq.size() < D);
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit   take_ex, take_ld, pick_ld;
    ent_t e;
    take_ex = ex_valid && m_ex_ready();
    take_ld = ld_valid && m_ld_ready();
    if (rst) begin
      exq.delete(); ldq.delete();
      m_last = 1'b1; m_flag = 1'b0; m_src = 1'b0;
      m_id = '0; m_val = '0; m_pc = '0;
    end else if (!rdy) begin
    end else if (flush) begin
      exq.delete(); ldq.delete();
      m_flag = 1'b0;
    end else begin
`ifdef CDB_FIXED_PRIO_EN
      pick_ld = ldq.size() != 0;
`else
      pick_ld = (ldq.size() != 0) && (exq.size() == 0 || m_last == 1'b0);
`endif
      if (pick_ld) begin
        e = ldq.pop_front();
        m_flag = 1'b1; m_src = 1'b1; m_id = e.id; m_val = e.val; m_pc = '0;
        m_last = 1'b1;
      end else if (exq.size() != 0) begin
        e = exq.pop_front();
        m_flag = 1'b1; m_src = 1'b0; m_id = e.id; m_val = e.val; m_pc = e.pc;
        m_last = 1'b0;
      end else begin
        m_flag = 1'b0;
      end
      if (take_ex) exq.push_back('{ex_rob_id, ex_val, ex_rel_pc});
      if (take_ld) ldq.push_back('{ld_rob_id, ld_val, 32'h0});
    end
  endtask

  // Called at a falling edge: apply inputs, check readies, step model,
  // cross the rising edge and compare registered outputs.
  task automatic cycle(input logic r, input logic en, input logic fl,
                       input logic ev, input logic [W-1:0] eid,
                       input logic [31:0] ev32, input logic [31:0] epc,
                       input logic lv, input logic [W-1:0] lid,
                       input logic [31:0] lv32);
    rst = r; rdy = en; flush = fl;
    ex_valid = ev; ex_rob_id = eid; ex_val = ev32; ex_rel_pc = epc;
    ld_valid = lv; ld_rob_id = lid; ld_val = lv32;
    #1;
    chk("ex_ready", {63'd0, ex_ready}, {63'd0, m_ex_ready()});
    chk("ld_ready", {63'd0, ld_ready}, {63'd0, m_ld_ready()});
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("cdb_flag", {63'd0, cdb_flag}, {63'd0, m_flag});
    if (m_flag) chk("cdb_src", {63'd0, cdb_src}, {63'd0, m_src});
    chk("cdb_rob_id", {60'd0, cdb_rob_id}, {60'd0, m_id});
    chk("cdb_val", {32'd0, cdb_val}, {32'd0, m_val});
    chk("cdb_rel_pc", {32'd0, cdb_rel_pc}, {32'd0, m_pc});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    logic [W-1:0] first_id, second_id;
    // Reset (model checks ready = 0 and cleared outputs).
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h1, 32'h2, 1'b1, 4'd9, 32'h3);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0);
    lit("reset_flag", {63'd0, cdb_flag}, 64'd0);
    lit("reset_val", {32'd0, cdb_val}, 64'd0);

    // Single ALU push: broadcast one cycle later, gone the next.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h11, 32'h104, 1'b0, '0, '0);
    lit("alu_push_noflag", {63'd0, cdb_flag}, 64'd0);
    idle();
    lit("alu_flag", {63'd0, cdb_flag}, 64'd1);
    lit("alu_src", {63'd0, cdb_src}, 64'd0);
    lit("alu_id", {60'd0, cdb_rob_id}, 64'd3);
    lit("alu_val", {32'd0, cdb_val}, 64'h11);
    lit("alu_pc", {32'd0, cdb_rel_pc}, 64'h104);
    idle();
    lit("alu_after_flag", {63'd0, cdb_flag}, 64'd0);

    // Load path.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd7, 32'hDEADBEEF);
    idle();
    lit("ld_src", {63'd0, cdb_src}, 64'd1);
    lit("ld_id", {60'd0, cdb_rob_id}, 64'd7);
    lit("ld_val", {32'd0, cdb_val}, 64'hDEADBEEF);
    lit("ld_pc", {32'd0, cdb_rel_pc}, 64'd0);
    idle();

    // Simultaneous pushes.
`ifdef CDB_FIXED_PRIO_EN
    first_id = 4'd2; second_id = 4'd1;
`else
    first_id = 4'd1; second_id = 4'd2;
`endif
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'hA1, 32'h200, 1'b1, 4'd2, 32'hB2);
    idle();
    lit("tie_first", {60'd0, cdb_rob_id}, {60'd0, first_id});
    idle();
    lit("tie_second", {60'd0, cdb_rob_id}, {60'd0, second_id});
    lit("tie_second_flag", {63'd0, cdb_flag}, 64'd1);
    idle();

    // Sustained dual offers for 8 cycles.
    for (int i = 0; i < 8; i++)
      cycle(1'b0, 1'b1, 1'b0, 1'b1, W'(i), 32'h100 + i, 32'h400 + i,
            1'b1, W'(8 + i), 32'h900 + i);
    for (int i = 0; i < 5; i++) idle();

    // Fill, flush, then a push one cycle after the flush.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 32'h8, 32'h8, 1'b1, 4'd9, 32'h9);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd10, 32'hA, 32'hA, 1'b1, 4'd11, 32'hB);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 32'hC, 32'hC, 1'b1, 4'd13, 32'hD);
    lit("flush_flag", {63'd0, cdb_flag}, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'h55, 32'h500, 1'b0, '0, '0);
    lit("post_flush_noflag", {63'd0, cdb_flag}, 64'd0);
    idle();
    lit("post_flush_flag", {63'd0, cdb_flag}, 64'd1);
    lit("post_flush_id", {60'd0, cdb_rob_id}, 64'd5);
    idle();

    // Freeze with entries buffered and a live broadcast.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 32'h1, 32'h1, 1'b1, 4'd2, 32'h2);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h3, 32'h3, 1'b1, 4'd4, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 32'h6, 32'h6, 1'b1, 4'd7, 32'h7);
      lit("freeze_ready", {63'd0, ex_ready}, 64'd0);
      lit("freeze_flag", {63'd0, cdb_flag}, 64'd1);
    end
    for (int i = 0; i < 4; i++) idle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 5) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, W'($urandom), $urandom, $urandom,
            $urandom_range(0, 3) != 0, W'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
